// File: rtl/spmmio_bridge_if.sv
// CPU-side and decoder-side Wishbone-classic signals of the MMIO bridge.
// The slave modport is the bridge's view; master is the environment driving it.
interface spmmio_bridge_if;
  logic [0:23] s_adr_i;
  logic        s_cyc_i;
  logic        s_stb_i;
  logic [0:3]  s_sel_i;
  logic        s_we_i;
  logic [0:31] s_dat_i;
  logic        s_ack_o;
  logic        s_err_o;
  logic [0:31] s_dat_o;
  logic [0:23] m_adr_o;
  logic        m_cyc_o;
  logic        m_stb_o;
  logic [0:3]  m_sel_o;
  logic        m_we_o;
  logic [0:31] m_dat_o;
  logic        m_ack_i;
  logic [0:31] m_dat_i;

  modport slave (
    input  s_adr_i, s_cyc_i, s_stb_i, s_sel_i, s_we_i, s_dat_i, m_ack_i, m_dat_i,
    output s_ack_o, s_err_o, s_dat_o, m_adr_o, m_cyc_o, m_stb_o, m_sel_o, m_we_o, m_dat_o
  );

  modport master (
    output s_adr_i, s_cyc_i, s_stb_i, s_sel_i, s_we_i, s_dat_i, m_ack_i, m_dat_i,
    input  s_ack_o, s_err_o, s_dat_o, m_adr_o, m_cyc_o, m_stb_o, m_sel_o, m_we_o, m_dat_o
  );
endinterface

// File: rtl/spmmio_bridge.sv
// Registered Wishbone-classic slice between CPU data bus and MMIO decoder,
// with a watchdog that aborts stalled accesses and sticky timeout diagnostics.
module spmmio_bridge #(
  parameter int unsigned TIMEOUT  = 1024,
  parameter int unsigned CW       = 11,
  parameter logic [31:0] ERR_DATA = 32'hFFFFFFFF
) (
  input  logic                  clk,
  input  logic                  reset,
  spmmio_bridge_if.slave        bus,
  input  logic                  timeout_clr,
  output logic                  timeout_flag,
  output logic [0:7]            timeout_count,
  output logic [0:23]           timeout_adr
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          expire;
  logic          s_ack_q, s_err_q;
  logic [0:31]   s_dat_q;
  logic [0:23]   m_adr_q;
  logic          m_cyc_q, m_stb_q, m_we_q;
  logic [0:3]    m_sel_q;
  logic [0:31]   m_dat_q;
  logic          tflag_q;
  logic [0:7]    tcount_q, tcount_d;
  logic [0:23]   tadr_q;

  always_comb begin
    cnt_d    = cnt_q + CW'(1);
    expire   = (cnt_q == CW'(TIMEOUT - 1));
    tcount_d = (tcount_q == 8'hFF) ? tcount_q : tcount_q + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      s_ack_q  <= 1'b0;
      s_err_q  <= 1'b0;
      s_dat_q  <= '0;
      m_adr_q  <= '0;
      m_cyc_q  <= 1'b0;
      m_stb_q  <= 1'b0;
      m_we_q   <= 1'b0;
      m_sel_q  <= '0;
      m_dat_q  <= '0;
      tflag_q  <= 1'b0;
      tcount_q <= '0;
      tadr_q   <= '0;
    end else begin
      s_ack_q <= 1'b0;
      s_err_q <= 1'b0;
      if (timeout_clr) begin
        tflag_q  <= 1'b0;
        tcount_q <= '0;
      end
      unique case (state_q)
        IDLE: begin
          if (bus.s_cyc_i && bus.s_stb_i) begin
            m_adr_q <= bus.s_adr_i;
            m_sel_q <= bus.s_sel_i;
            m_we_q  <= bus.s_we_i;
            m_dat_q <= bus.s_dat_i;
            m_cyc_q <= 1'b1;
            m_stb_q <= 1'b1;
            cnt_q   <= '0;
            state_q <= REQ;
          end
        end
        REQ: begin
          // Ack beats both a CPU abandon and a watchdog expiry in the same cycle.
          if (bus.m_ack_i) begin
            s_dat_q <= bus.m_dat_i;
            m_cyc_q <= 1'b0;
            m_stb_q <= 1'b0;
            s_ack_q <= 1'b1;
            state_q <= RESP;
          end else if (!bus.s_cyc_i) begin
            m_cyc_q <= 1'b0;
            m_stb_q <= 1'b0;
            state_q <= IDLE;
          end else if (expire) begin
            m_cyc_q  <= 1'b0;
            m_stb_q  <= 1'b0;
            s_dat_q  <= ERR_DATA;
            s_ack_q  <= 1'b1;
            s_err_q  <= 1'b1;
            tflag_q  <= 1'b1;
            // A coincident clear restarts the count at this abort.
            tcount_q <= timeout_clr ? 8'd1 : tcount_d;
            tadr_q   <= m_adr_q;
            state_q  <= RESP;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.s_ack_o    = s_ack_q;
  assign bus.s_err_o    = s_err_q;
  assign bus.s_dat_o    = s_dat_q;
  assign bus.m_adr_o    = m_adr_q;
  assign bus.m_cyc_o    = m_cyc_q;
  assign bus.m_stb_o    = m_stb_q;
  assign bus.m_sel_o    = m_sel_q;
  assign bus.m_we_o     = m_we_q;
  assign bus.m_dat_o    = m_dat_q;
  assign timeout_flag   = tflag_q;
  assign timeout_count  = tcount_q;
  assign timeout_adr    = tadr_q;

endmodule
